// File: rtl/cdma_half_launcher_if.sv
// AXI4-Lite bus between the half launcher (master) and the AXI CDMA register file (slave).
interface cdma_half_launcher_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cdma_half_launcher.sv
// Turns each toggle of the capture half-complete flag into one AXI CDMA copy of that
// BRAM half into a DDR ring, then polls CDMA status until idle.
module cdma_half_launcher #(
  parameter logic [31:0] CDMA_BASE  = 32'h7E20_0000,
  parameter logic [31:0] DST_BASE   = 32'h1000_0000,
  parameter logic [31:0] DST_SIZE   = 32'h0100_0000,
  parameter logic [31:0] HALF_BYTES = 32'h0004_0000,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                 m00_axi_aclk,
  input  logic                 m00_axi_areset,
  input  logic                 half_in,
  input  logic [31:0]          src_addr_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 overrun,
  output logic [15:0]          xfer_count,
  cdma_half_launcher_if.master m00_axi
);

  localparam logic [31:0] OFS_SR  = 32'h0000_0004;
  localparam logic [31:0] OFS_SA  = 32'h0000_0018;
  localparam logic [31:0] OFS_DA  = 32'h0000_0020;
  localparam logic [31:0] OFS_BTT = 32'h0000_0028;
  localparam logic [31:0] DST_END = DST_BASE + DST_SIZE;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_SA  = 3'd1,
    S_WR_DA  = 3'd2,
    S_WR_BTT = 3'd3,
    S_POLL   = 3'd4,
    S_FINISH = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic                    half_q;
  logic                    slot_valid_q, slot_valid_d;
  logic [31:0]             slot_addr_q, slot_addr_d;
  logic [31:0]             dst_q, dst_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    overrun_q, overrun_d;
  logic [15:0]             xfer_count_q, xfer_count_d;
  logic                    awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                    wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;

  logic                    edge_s;
  logic                    b_hs_s;
  logic                    r_hs_s;
  logic                    rd_err_s;
  logic [31:0]             dst_inc_s;

  assign edge_s    = half_in ^ half_q;
  assign b_hs_s    = m00_axi.bvalid && bready_q;
  assign r_hs_s    = m00_axi.rvalid && rready_q;
  assign rd_err_s  = (m00_axi.rresp != 2'b00) || (m00_axi.rdata[6:4] != 3'b000);
  assign dst_inc_s = dst_q + HALF_BYTES;

  // Pending-request slot: one half may wait while a transfer is running; further edges overrun.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    overrun_d    = overrun_q;
    if ((state_q == S_IDLE) && slot_valid_q) begin
      slot_valid_d = 1'b0;
    end else begin
      slot_valid_d = slot_valid_q;
    end
    if (edge_s) begin
      if (slot_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        slot_valid_d = 1'b1;
        slot_addr_d  = src_addr_in;
      end
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Request-side registers: flag history and pending slot.
  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      half_q       <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_addr_q  <= 32'h0000_0000;
      overrun_q    <= 1'b0;
    end else begin
      half_q       <= half_in;
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      overrun_q    <= overrun_d;
    end
  end

  // Sequencer state register.
  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next state: three register writes, status polling, then finish or error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (slot_valid_q) begin
          state_d = S_WR_SA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_SA, S_WR_DA, S_WR_BTT: begin
        if (b_hs_s) begin
          if (m00_axi.bresp != 2'b00) begin
            state_d = S_ERR;
          end else if (state_q == S_WR_SA) begin
            state_d = S_WR_DA;
          end else if (state_q == S_WR_DA) begin
            state_d = S_WR_BTT;
          end else begin
            state_d = S_POLL;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_POLL: begin
        if (r_hs_s) begin
          if (rd_err_s) begin
            state_d = S_ERR;
          end else if (m00_axi.rdata[1]) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_POLL;
          end
        end else begin
          state_d = S_POLL;
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Sequencer outputs: bus valids/readies and status, loaded on the transition into each state
  // so that every output comes straight from a flop.
  always_comb begin
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    xfer_count_d = xfer_count_q;
    dst_d        = dst_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    bready_d     = bready_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q && !m00_axi.awready;
    wvalid_d     = wvalid_q && !m00_axi.wready;
    arvalid_d    = arvalid_q && !m00_axi.arready;
    if (state_d != state_q) begin
      case (state_d)
        S_WR_SA: begin
          busy_d    = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
          awaddr_d  = ADDR_WIDTH'(CDMA_BASE + OFS_SA);
          wdata_d   = DATA_WIDTH'(slot_addr_q);
        end
        S_WR_DA: begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = ADDR_WIDTH'(CDMA_BASE + OFS_DA);
          wdata_d   = DATA_WIDTH'(dst_q);
        end
        S_WR_BTT: begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = ADDR_WIDTH'(CDMA_BASE + OFS_BTT);
          wdata_d   = DATA_WIDTH'(HALF_BYTES);
        end
        S_POLL: begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
        end
        S_FINISH: begin
          arvalid_d    = 1'b0;
          rready_d     = 1'b0;
          done_d       = 1'b1;
          busy_d       = 1'b0;
          xfer_count_d = xfer_count_q + 16'd1;
          dst_d        = (dst_inc_s == DST_END) ? DST_BASE : dst_inc_s;
        end
        S_ERR: begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          err_d     = 1'b1;
          busy_d    = 1'b1;
        end
        default: begin
          busy_d = busy_q;
        end
      endcase
    end else if ((state_q == S_POLL) && r_hs_s) begin
      // Status not yet idle: issue the next read straight away.
      arvalid_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  // Output and bus registers; every valid clears asynchronously on reset.
  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      dst_q        <= DST_BASE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      xfer_count_q <= 16'h0000;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      dst_q        <= dst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      xfer_count_q <= xfer_count_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign overrun    = overrun_q;
  assign xfer_count = xfer_count_q;

  assign m00_axi.awaddr  = awaddr_q;
  assign m00_axi.awvalid = awvalid_q;
  assign m00_axi.wdata   = wdata_q;
  assign m00_axi.wstrb   = {(DATA_WIDTH/8){1'b1}};
  assign m00_axi.wvalid  = wvalid_q;
  assign m00_axi.bready  = bready_q;
  assign m00_axi.araddr  = ADDR_WIDTH'(CDMA_BASE + OFS_SR);
  assign m00_axi.arvalid = arvalid_q;
  assign m00_axi.rready  = rready_q;

endmodule
